rr_merge2: RTL and testbench

RR_MERGE2 -- requirements
Module: rr_merge2

---
 rtl/fluid_arb_pkg.sv | 19 +
 rtl/fflop.sv | 59 +++++
 rtl/rr_pick2.sv | 24 ++
 rtl/rr_merge2.sv | 161 ++++++++++++++++
 tb/tb_rr_merge2.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fluid_arb_pkg.sv
// Shared types and constants for the two-input round-robin merge.
// src_t names the requester a payload came from; GRANT_CNT_W sizes the
// optional per-requester grant counters.
package fluid_arb_pkg;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_t;

  localparam int GRANT_CNT_W = 16;

  // The requester that is not s; used to turn the round-robin pointer
  // into the winner of a tie.
  function automatic src_t otherSrc(src_t s);
    return (s == SRC_A) ? SRC_B : SRC_A;
  endfunction

endpackage

// File: rtl/fflop.sv
// Fluid flop: a two-entry valid/retry pipeline stage.
// dinRetry depends only on the entry count, so it is a registered signal
// and back-to-back transfers still run at one item per cycle.
// Data slots are not reset; only the occupancy count is.
module fflop #(
  parameter int Size = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic [Size-1:0] din,
  input  logic            dinValid,
  output logic            dinRetry,
  output logic [Size-1:0] q,
  output logic            qValid,
  input  logic            qRetry
);

  logic [Size-1:0] headReg;
  logic [Size-1:0] tailReg;
  logic [1:0]      cntReg;
  logic            push;
  logic            pop;

  assign dinRetry = (cntReg == 2'd2);
  assign qValid   = (cntReg != 2'd0);
  assign q        = headReg;
  assign push     = dinValid && !dinRetry;
  assign pop      = qValid && !qRetry;

  // Occupancy count: +1 on push, -1 on pop; reset and clear empty the stage.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cntReg <= 2'd0;
    end else begin
      case (cntReg)
        2'd0:    if (push) cntReg <= 2'd1;
        2'd1:    if (push && !pop) cntReg <= 2'd2;
                 else if (!push && pop) cntReg <= 2'd0;
        2'd2:    if (pop) cntReg <= 2'd1;
        default: cntReg <= 2'd0;
      endcase
    end
  end

  // Data slots: head is always the oldest item, tail the second oldest.
  always_ff @(posedge clk) begin
    case (cntReg)
      2'd0: if (push) headReg <= din;
      2'd1: begin
        if (push && pop) headReg <= din;
        else if (push) tailReg <= din;
      end
      2'd2: if (pop) headReg <= tailReg;
      default: ;
    endcase
  end

endmodule

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin pick. A lone requester always wins;
// on a tie the requester other than lastSrc wins.
module rr_pick2
  import fluid_arb_pkg::*;
(
  input  logic aValid,
  input  logic bValid,
  input  src_t lastSrc,
  output src_t grant,
  output logic grantValid
);

  // Select the winner from the two valids and the round-robin pointer.
  always_comb begin
    grantValid = aValid || bValid;
    grant      = SRC_A;
    if (aValid && bValid) begin
      grant = otherSrc(lastSrc);
    end else if (bValid) begin
      grant = SRC_B;
    end
  end

endmodule

// File: rtl/rr_merge2.sv
// rr_merge2: merges two valid/retry requesters into one valid/retry stream.
// Each requester passes through its own fflop, a combinational round-robin
// pick chooses which head moves into the output fflop, and the output fflop
// carries {source, payload}. Minimum latency is two cycles.
// Optional feature: define RR_MERGE2_GRANT_CNT_EN to add 16-bit wrapping
// per-requester grant counters on ports grantCntA / grantCntB.
module rr_merge2
  import fluid_arb_pkg::*;
#(
  parameter int Size = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [Size-1:0] inp_a,
  input  logic            inp_aValid,
  output logic            inp_aRetry,
  input  logic [Size-1:0] inp_b,
  input  logic            inp_bValid,
  output logic            inp_bRetry,
  output logic [Size-1:0] out,
  output logic            outSrc,
  output logic            outValid,
  input  logic            outRetry
`ifdef RR_MERGE2_GRANT_CNT_EN
  ,
  output logic [GRANT_CNT_W-1:0] grantCntA,
  output logic [GRANT_CNT_W-1:0] grantCntB
`endif
);

  // Input stage signals, index 0 = A, 1 = B.
  logic [Size-1:0] inDin [2];
  logic [1:0]      inDinValid;
  logic [1:0]      inDinRetry;
  logic [Size-1:0] inQ [2];
  logic [1:0]      inQValid;
  logic [1:0]      inQRetry;

  // Output stage signals.
  logic [Size:0]   outDin;
  logic            outDinValid;
  logic            outDinRetry;
  logic [Size:0]   outQ;

  // Arbitration.
  src_t            pickSrc;
  logic            pickValid;
  src_t            selSrc;
  logic            selValid;
  logic [Size-1:0] selData;
  logic            accept;
  src_t            lastSrcReg;
  logic            lockValidReg;
  src_t            lockSrcReg;

  assign inDin[0]      = inp_a;
  assign inDin[1]      = inp_b;
  assign inDinValid[0] = inp_aValid;
  assign inDinValid[1] = inp_bValid;
  assign inp_aRetry    = inDinRetry[0];
  assign inp_bRetry    = inDinRetry[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gInStage
      localparam src_t MySrc = (gi == 0) ? SRC_A : SRC_B;

      fflop #(.Size(Size)) uInFlop (
        .clk      (clk),
        .reset    (reset),
        .clear    (1'b0),
        .din      (inDin[gi]),
        .dinValid (inDinValid[gi]),
        .dinRetry (inDinRetry[gi]),
        .q        (inQ[gi]),
        .qValid   (inQValid[gi]),
        .qRetry   (inQRetry[gi])
      );

      // A losing stage is always held; the winner sees the output stage's retry.
      assign inQRetry[gi] = !(selValid && (selSrc == MySrc)) || outDinRetry;
    end
  endgenerate

  rr_pick2 uPick (
    .aValid     (inQValid[0]),
    .bValid     (inQValid[1]),
    .lastSrc    (lastSrcReg),
    .grant      (pickSrc),
    .grantValid (pickValid)
  );

  // A grant that was retried last cycle stays in force until accepted, so a
  // newly valid requester cannot steal an already presented transfer.
  assign selSrc   = lockValidReg ? lockSrcReg : pickSrc;
  assign selValid = lockValidReg ? ((lockSrcReg == SRC_A) ? inQValid[0] : inQValid[1])
                                 : pickValid;
  assign selData  = (selSrc == SRC_B) ? inQ[1] : inQ[0];
  assign accept   = selValid && !outDinRetry;

  assign outDin      = {selSrc, selData};
  assign outDinValid = selValid;

  fflop #(.Size(Size + 1)) uOutFlop (
    .clk      (clk),
    .reset    (reset),
    .clear    (1'b0),
    .din      (outDin),
    .dinValid (outDinValid),
    .dinRetry (outDinRetry),
    .q        (outQ),
    .qValid   (outValid),
    .qRetry   (outRetry)
  );

  assign out    = outQ[Size-1:0];
  assign outSrc = outQ[Size];

  // Round-robin pointer moves only when the output stage takes the grant;
  // resetting it to B makes A win the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      lastSrcReg <= SRC_B;
    end else if (accept) begin
      lastSrcReg <= selSrc;
    end
  end

  // Remember a presented-but-retried grant for the following cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      lockValidReg <= 1'b0;
      lockSrcReg   <= SRC_A;
    end else begin
      lockValidReg <= selValid && outDinRetry;
      lockSrcReg   <= selSrc;
    end
  end

`ifdef RR_MERGE2_GRANT_CNT_EN
  logic [GRANT_CNT_W-1:0] grantCntAReg;
  logic [GRANT_CNT_W-1:0] grantCntBReg;

  // Count accepted grants per source; natural wrap at the counter width.
  always_ff @(posedge clk) begin
    if (reset) begin
      grantCntAReg <= '0;
      grantCntBReg <= '0;
    end else if (accept) begin
      if (selSrc == SRC_A) grantCntAReg <= grantCntAReg + 1'b1;
      else                 grantCntBReg <= grantCntBReg + 1'b1;
    end
  end

  assign grantCntA = grantCntAReg;
  assign grantCntB = grantCntBReg;
`else
  // Grant counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_rr_merge2.sv
// Directed bench for rr_merge2: reset state, single-item latency, tie
// alternation and throughput, backpressure fill/drain, grant hold under
// retry, mid-stream reset, and (with RR_MERGE2_GRANT_CNT_EN) counter wrap.
module tb_rr_merge2;
  import fluid_arb_pkg::*;

  localparam int Size = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [Size-1:0] inp_a;
  logic            inp_aValid;
  logic            inp_aRetry;
  logic [Size-1:0] inp_b;
  logic            inp_bValid;
  logic            inp_bRetry;
  logic [Size-1:0] out;
  logic            outSrc;
  logic            outValid;
  logic            outRetry;
`ifdef RR_MERGE2_GRANT_CNT_EN
  logic [GRANT_CNT_W-1:0] grantCntA;
  logic [GRANT_CNT_W-1:0] grantCntB;
`endif

  always #5 clk = ~clk;

  rr_merge2 #(.Size(Size)) dut (
    .clk        (clk),
    .reset      (reset),
    .inp_a      (inp_a),
    .inp_aValid (inp_aValid),
    .inp_aRetry (inp_aRetry),
    .inp_b      (inp_b),
    .inp_bValid (inp_bValid),
    .inp_bRetry (inp_bRetry),
    .out        (out),
    .outSrc     (outSrc),
    .outValid   (outValid),
    .outRetry   (outRetry)
`ifdef RR_MERGE2_GRANT_CNT_EN
    ,
    .grantCntA  (grantCntA),
    .grantCntB  (grantCntB)
`endif
  );

  int nVec = 0;
  int nErr = 0;

  logic [7:0] aQ [$];
  logic [7:0] bQ [$];
  logic [8:0] rx [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    inp_aValid = (aQ.size() > 0);
    inp_a      = (aQ.size() > 0) ? aQ[0] : 8'h00;
    inp_bValid = (bQ.size() > 0);
    inp_b      = (bQ.size() > 0) ? bQ[0] : 8'h00;
  endtask

  // One clock: note which handshakes complete at the coming edge, log output
  // transfers, then advance the source queues and re-drive.
  task automatic tick();
    logic aX, bX, oX;
    aX = inp_aValid && !inp_aRetry;
    bX = inp_bValid && !inp_bRetry;
    oX = outValid && !outRetry;
    if (oX) begin
      rx.push_back({outSrc, out});
      $display("out xfer src=%0d data=%02h", outSrc, out);
    end
    @(posedge clk);
    #1;
    if (aX) void'(aQ.pop_front());
    if (bX) void'(bQ.pop_front());
    drive();
  endtask

  task automatic doReset();
    reset    = 1'b1;
    outRetry = 1'b0;
    aQ.delete();
    bQ.delete();
    drive();
    tick();
    tick();
    reset = 1'b0;
    rx.delete();
  endtask

  // Wait for n logged output items, bounded; returns ticks used.
  task automatic runUntil(input int n, input int budget, input string tag, output int used);
    used = 0;
    while (rx.size() < n && used < budget) begin
      tick();
      used++;
    end
    chk(tag, rx.size(), n);
  endtask

  initial begin
    int used;
    bit found;
    logic [8:0] expSeq [$];

    reset      = 1'b1;
    outRetry   = 1'b0;
    inp_a      = '0;
    inp_aValid = 1'b0;
    inp_b      = '0;
    inp_bValid = 1'b0;

    // Reset state after the first reset edge.
    @(posedge clk);
    #1;
    chk("rst_outValid", outValid, 0);
    chk("rst_aRetry", inp_aRetry, 0);
    chk("rst_bRetry", inp_bRetry, 0);
    tick();
    reset = 1'b0;

    // Single A item: accepted at edge t, visible after edge t+1.
    aQ.push_back(8'h11);
    drive();
    tick();
    chk("single_early", outValid, 0);
    tick();
    chk("single_valid", outValid, 1);
    chk("single_data", out, 8'h11);
    chk("single_src", outSrc, 0);
    tick();

    // Tie: A wins first, strict alternation, one item per cycle.
    doReset();
    for (int i = 1; i <= 4; i++) begin
      aQ.push_back(8'(i));
      bQ.push_back(8'(8'h80 + i));
    end
    drive();
    runUntil(8, 40, "tie_count", used);
    chk("tie_cycles", used, 10);
    for (int i = 0; i < 8; i++) begin
      if (i < rx.size())
        chk($sformatf("tie_item%0d", i), rx[i],
            (i % 2 == 0) ? {1'b0, 8'(i / 2 + 1)} : {1'b1, 8'(8'h81 + i / 2)});
      else
        chk($sformatf("tie_item%0d", i), 9'h1ff, 9'h000);
    end

    // Backpressure: stall the consumer for 10 cycles while both stream.
    doReset();
    expSeq.delete();
    for (int i = 0; i < 8; i++) begin
      aQ.push_back(8'(8'h21 + i));
      bQ.push_back(8'(8'ha1 + i));
      expSeq.push_back({1'b0, 8'(8'h21 + i)});
      expSeq.push_back({1'b1, 8'(8'ha1 + i)});
    end
    drive();
    repeat (3) tick();
    outRetry = 1'b1;
    repeat (4) tick();
    chk("bp_aRetry", inp_aRetry, 1);
    chk("bp_bRetry", inp_bRetry, 1);
    repeat (6) tick();
    chk("bp_outHeld", outValid, 1);
    outRetry = 1'b0;
    runUntil(16, 60, "bp_count", used);
    for (int i = 0; i < 16; i++) begin
      if (i < rx.size()) chk($sformatf("bp_item%0d", i), rx[i], expSeq[i]);
      else               chk($sformatf("bp_item%0d", i), 9'h1ff, expSeq[i]);
    end

    // Grant hold: retry while B is presented; it must stay put, no duplicates.
    doReset();
    for (int i = 1; i <= 3; i++) begin
      aQ.push_back(8'(i));
      bQ.push_back(8'(8'h80 + i));
    end
    drive();
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      tick();
      if (outValid && outSrc && out == 8'h81) found = 1'b1;
    end
    chk("hold_found", found, 1);
    outRetry = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("hold_data%0d", k), out, 8'h81);
      chk($sformatf("hold_src%0d", k), outSrc, 1);
    end
    outRetry = 1'b0;
    runUntil(6, 30, "hold_count", used);
    expSeq = '{9'h001, 9'h181, 9'h002, 9'h182, 9'h003, 9'h183};
    for (int i = 0; i < 6; i++) begin
      if (i < rx.size()) chk($sformatf("hold_item%0d", i), rx[i], expSeq[i]);
      else               chk($sformatf("hold_item%0d", i), 9'h1ff, expSeq[i]);
    end

    // Mid-stream reset discards buffered items; next item has normal latency.
    doReset();
    for (int i = 0; i < 3; i++) begin
      aQ.push_back(8'(8'h31 + i));
      bQ.push_back(8'(8'hb1 + i));
    end
    drive();
    outRetry = 1'b1;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    chk("mrst_outValid", outValid, 0);
    chk("mrst_aRetry", inp_aRetry, 0);
    chk("mrst_bRetry", inp_bRetry, 0);
    reset    = 1'b0;
    outRetry = 1'b0;
    aQ.delete();
    bQ.delete();
    rx.delete();
    aQ.push_back(8'h55);
    drive();
    tick();
    chk("mrst_early", outValid, 0);
    tick();
    chk("mrst_valid", outValid, 1);
    chk("mrst_data", out, 8'h55);
    chk("mrst_src", outSrc, 0);
    tick();

`ifdef RR_MERGE2_GRANT_CNT_EN
    // 65537 A grants wrap the A counter to 1; B stays 0.
    begin
      int n;
      int guard;
      doReset();
      chk("cnt_rstA", grantCntA, 0);
      chk("cnt_rstB", grantCntB, 0);
      inp_a      = 8'h5a;
      inp_aValid = 1'b1;
      n = 0;
      guard = 0;
      while (n < 65537 && guard < 70000) begin
        if (inp_aValid && !inp_aRetry) n++;
        @(posedge clk);
        #1;
        guard++;
        if (n == 65537) inp_aValid = 1'b0;
      end
      inp_aValid = 1'b0;
      chk("cnt_sent", n, 65537);
      repeat (6) @(posedge clk);
      #1;
      chk("cnt_A", grantCntA, 1);
      chk("cnt_B", grantCntB, 0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
